// File: rtl/memory_writer.sv
// memory_writer: writes one BEATS*64-bit line on Mybus as an address beat plus
// BEATS data beats. Define MEMORY_WRITER_ALIGN_EN to line-align the address.
package MYBUS;
  typedef logic [12:0] tag_t;
  localparam tag_t READ_MEM_TAG  = 13'h0500;
  localparam tag_t WRITE_MEM_TAG = 13'h0501;
endpackage

interface Mybus;
  import MYBUS::*;
  logic        bid;
  logic        reqcyc;
  tag_t        reqtag;
  logic [63:0] req;
  logic        respack;
  logic        reqack;
  modport Top (
    output bid, reqcyc, reqtag, req, respack,
    input  reqack
  );
endinterface

module memory_writer
  import MYBUS::*;
#(
  parameter int BEATS = 8
) (
  input  logic                clk,
  input  logic                reset,
  Mybus.Top                   bus,
  input  logic                reqcyc,
  input  logic [63:0]         addr,
  input  logic [0:64*BEATS-1] data,
  output logic                busy,
  output logic                respcyc
);
  localparam int BW = (BEATS > 1) ? $clog2(BEATS) : 1;
  localparam logic [BW-1:0] LAST = BW'(BEATS - 1);

  typedef enum logic [1:0] {
    IDLE,
    ADDR,
    DATA,
    DONE
  } state_e;

  state_e              state_q;
  logic [BW-1:0]       beat_q;
  logic [BW-1:0]       beat_d;
  logic [63:0]         addr_q;
  logic [63:0]         addr_d;
  logic [0:64*BEATS-1] buf_q;
  logic                bid_q;
  logic                busy_q;
  logic                resp_q;
  tag_t                tag_q;
  logic [63:0]         req_w;

  function automatic logic [63:0] word(
    input logic [0:64*BEATS-1] l,
    input logic [BW-1:0]       i
  );
    return l[int'(i)*64 +: 64];
  endfunction

  always_comb begin
`ifdef MEMORY_WRITER_ALIGN_EN
    addr_d = addr & ~64'h3f;
`else
    addr_d = addr;
`endif
  end

  assign beat_d = beat_q + 1'b1;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      beat_q  <= '0;
      addr_q  <= '0;
      buf_q   <= '0;
      bid_q   <= 1'b0;
      busy_q  <= 1'b0;
      resp_q  <= 1'b0;
      tag_q   <= READ_MEM_TAG;
    end else begin
      case (state_q)
        IDLE: begin
          if (reqcyc) begin
            state_q <= ADDR;
            addr_q  <= addr_d;
            buf_q   <= data;
            beat_q  <= '0;
            bid_q   <= 1'b1;
            busy_q  <= 1'b1;
            tag_q   <= WRITE_MEM_TAG;
          end
        end
        ADDR: begin
          if (bus.reqack) state_q <= DATA;
        end
        DATA: begin
          if (bus.reqack) begin
            if (beat_q == LAST) begin
              state_q <= DONE;
              bid_q   <= 1'b0;
              tag_q   <= READ_MEM_TAG;
              resp_q  <= 1'b1;
            end else begin
              beat_q <= beat_d;
            end
          end
        end
        DONE: begin
          state_q <= IDLE;
          busy_q  <= 1'b0;
          resp_q  <= 1'b0;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  // Beat payload is a pure decode of registered state, so reset clears it too.
  always_comb begin
    req_w = '0;
    case (state_q)
      ADDR:    req_w = addr_q;
      DATA:    req_w = word(buf_q, beat_q);
      default: req_w = '0;
    endcase
  end

  assign bus.bid     = bid_q;
  assign bus.reqcyc  = bid_q;
  assign bus.reqtag  = tag_q;
  assign bus.req     = req_w;
  assign bus.respack = 1'b0;
  assign busy        = busy_q;
  assign respcyc     = resp_q;

endmodule
